// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Parses 5-byte command frames {SYNC_BYTE, OP, A, B, CHK} from a UART
//   receiver byte stream. A frame is good when CHK == OP ^ A ^ B and the upper
//   opcode nibble is zero. A good frame loads cmd_* and pulses cmd_valid. A bad
//   frame, or too long a gap between bytes inside a frame, pulses frame_err.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   data_in    : received byte
//   data_valid : one-cycle strobe, data_in holds a new byte
//   cmd_valid  : one-cycle pulse, a good frame was accepted
//   cmd_op     : opcode (OP[3:0]) of the last good frame
//   cmd_a      : operand A of the last good frame
//   cmd_b      : operand B of the last good frame
//   frame_err  : one-cycle pulse on checksum, opcode-format or timeout error
//   err_count  : saturating count of frame_err pulses
//   busy       : high while a frame is in progress (state != WAIT_SYNC)
//
// State     | meaning
// ----------+-------------------------------------------------
// WAIT_SYNC | idle, discarding bytes until SYNC_BYTE arrives
// GET_OP    | waiting for the opcode byte
// GET_A     | waiting for operand A
// GET_B     | waiting for operand B
// GET_CHK   | waiting for the checksum byte, then judge the frame

module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       cmd_valid,
  output logic [3:0] cmd_op,
  output logic [7:0] cmd_a,
  output logic [7:0] cmd_b,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  // One spare bit so TIMEOUT_CLKS-1 always fits; the counter is cleared on
  // the timeout cycle, so it never reaches the top of its range.
  localparam int                CNT_W     = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    WAIT_SYNC,
    GET_OP,
    GET_A,
    GET_B,
    GET_CHK
  } state_t;

  state_t           state, state_n;
  logic [7:0]       op_q, a_q, b_q;
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout;
  logic             frame_good;
  logic             cmd_valid_n;
  logic             frame_err_n;

  assign busy = (state != WAIT_SYNC);

  // A byte arriving on the timeout cycle takes priority over the timeout.
  assign timeout    = busy && !data_valid && (idle_cnt == IDLE_LAST);
  assign frame_good = (data_in == (op_q ^ a_q ^ b_q)) && (op_q[7:4] == 4'h0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cmd_valid_n = 1'b0;
    frame_err_n = 1'b0;
    if (timeout) begin
      state_n     = WAIT_SYNC;
      frame_err_n = 1'b1;
    end else if (data_valid) begin
      case (state)
        WAIT_SYNC: if (data_in == SYNC_BYTE) state_n = GET_OP;
        GET_OP:    state_n = GET_A;
        GET_A:     state_n = GET_B;
        GET_B:     state_n = GET_CHK;
        GET_CHK: begin
          state_n = WAIT_SYNC;
          if (frame_good) cmd_valid_n = 1'b1;
          else            frame_err_n = 1'b1;
        end
        default:   state_n = WAIT_SYNC;
      endcase
    end
  end

  // Shadow registers for the frame body.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 8'h00;
      a_q  <= 8'h00;
      b_q  <= 8'h00;
    end else if (data_valid) begin
      case (state)
        GET_OP:  op_q <= data_in;
        GET_A:   a_q  <= data_in;
        GET_B:   b_q  <= data_in;
        default: ;
      endcase
    end
  end

  // Inter-byte idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      idle_cnt <= '0;
    else if (data_valid || state_n == WAIT_SYNC)  idle_cnt <= '0;
    else if (busy)                                idle_cnt <= idle_cnt + CNT_W'(1);
  end

  // Result outputs, registered one cycle after the judging cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_op    <= 4'h0;
      cmd_a     <= 8'h00;
      cmd_b     <= 8'h00;
      err_count <= 8'h00;
    end else begin
      cmd_valid <= cmd_valid_n;
      frame_err <= frame_err_n;
      if (cmd_valid_n) begin
        cmd_op <= op_q[3:0];
        cmd_a  <= a_q;
        cmd_b  <= b_q;
      end
      // Count moves on the same edge that raises frame_err.
      if (frame_err_n && err_count != 8'hFF) err_count <= err_count + 8'h01;
    end
  end

endmodule
